// File: rtl/btn_reader_if.sv
// btn_reader_if: CPU data-bus signals shared by the button reader and its bus master
//
// Signals:
//   data_addr  - CPU data word address
//   data_wr    - CPU write data
//   data_wr_en - CPU byte write enables (all four set = full-word write)
//   data_rd    - peripheral read data, zero when the address does not match
// Modports:
//   master - CPU side (drives address/write, receives read data)
//   slave  - peripheral side
interface btn_reader_if;
    logic [31:0] data_addr;
    logic [31:0] data_wr;
    logic [3:0]  data_wr_en;
    logic [31:0] data_rd;

    modport master (output data_addr, output data_wr, output data_wr_en, input data_rd);
    modport slave  (input data_addr, input data_wr, input data_wr_en, output data_rd);
endinterface

// File: rtl/btn_reader.sv
// btn_reader: memory-mapped debounced button reader with sticky W1C edge flags
//
// Parameters:
//   BASE_ADDR       - word address of STATE; EVENT lives at BASE_ADDR+4
//   WIDTH           - number of buttons (1..16)
//   DEBOUNCE_CYCLES - cycles a new level must persist before it is accepted (>=1)
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   btn   - raw asynchronous button levels, 1 = pressed
//   bus   - slave side of the CPU data bus (combinational read, full-word W1C write)
//   irq   - registered OR of all EVENT flags
// Build option:
//   BTN_FALL_EDGE_EN - when defined, EVENT[16+WIDTH-1:16] hold sticky falling-edge flags
module btn_reader #(
    parameter logic [31:0] BASE_ADDR       = 32'h2000_0010,
    parameter int          WIDTH           = 4,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn,
    btn_reader_if.slave      bus,
    output logic             irq
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, stable, rise_ev;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] at_last, upd, rise_set, clr_rise;
    logic             wr_event;
    logic [31:0]      ev_word;
    logic             any_ev;
    logic             unused_wr;

    assign unused_wr = ^bus.data_wr;
    assign wr_event  = (bus.data_wr_en == 4'b1111) && (bus.data_addr == BASE_ADDR + 32'd4);
    assign clr_rise  = wr_event ? bus.data_wr[WIDTH-1:0] : '0;

    always_comb begin
        at_last = '0;
        for (int i = 0; i < WIDTH; i++) at_last[i] = (cnt[i] == LAST);
    end

    // A bit flips only when it disagrees with the synchronised input on the final count.
    assign upd      = (sync2 ^ stable) & at_last;
    assign rise_set = upd & sync2;

`ifdef BTN_FALL_EDGE_EN
    logic [WIDTH-1:0] fall_ev, fall_set, clr_fall;
    assign fall_set = upd & ~sync2;
    assign clr_fall = wr_event ? bus.data_wr[16 +: WIDTH] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fall_ev <= '0;
        else fall_ev <= (fall_ev & ~clr_fall) | fall_set;
    end
    assign any_ev = |{rise_ev, fall_ev};
`else
    assign any_ev = |rise_ev;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            rise_ev <= '0;
            irq     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            stable  <= stable ^ upd;
            // Clear first, then set, so a same-edge rise keeps the flag.
            rise_ev <= (rise_ev & ~clr_rise) | rise_set;
            irq     <= any_ev;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= (sync2[i] == stable[i] || at_last[i]) ? '0 : cnt[i] + 1'b1;
        end
    end

    always_comb begin
        ev_word = '0;
        ev_word[WIDTH-1:0] = rise_ev;
`ifdef BTN_FALL_EDGE_EN
        ev_word[16 +: WIDTH] = fall_ev;
`endif
    end

    assign bus.data_rd = (bus.data_addr == BASE_ADDR)          ? 32'(stable) :
                         (bus.data_addr == BASE_ADDR + 32'd4) ? ev_word     : 32'h0;
endmodule

// File: tb/tb_btn_reader.sv
// tb_btn_reader: randomized self-checking bench for btn_reader against a behavioural model
module tb_btn_reader;
    localparam logic [31:0] BASE = 32'h2000_0010;
    localparam logic [31:0] EVA  = 32'h2000_0014;
    localparam int D = 8;
`ifdef BTN_FALL_EDGE_EN
    localparam bit FALL = 1'b1;
`else
    localparam bit FALL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'hF;
    logic       irq;
    int         checks = 0;
    int         failures = 0;

    btn_reader_if bus ();

    btn_reader #(.BASE_ADDR(BASE), .WIDTH(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .bus(bus), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the input seen two samples late has
    // differed from the accepted level for D consecutive edges.
    logic [3:0] m_st = '0, m_ev = '0, m_evf = '0;
    logic       m_irq = 1'b0;
    logic [3:0] hist[$] = '{4'h0, 4'h0};
    int         run[4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = '0; m_ev = '0; m_evf = '0; m_irq = 1'b0;
            hist = '{4'h0, 4'h0};
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            logic [3:0] seen, rise, fall, clr, clrf;
            logic       full;
            m_irq = |{m_ev, m_evf};
            seen  = hist[0];
            hist.push_back(btn);
            void'(hist.pop_front());
            rise = '0; fall = '0;
            for (int i = 0; i < 4; i++) begin
                run[i] = (seen[i] != m_st[i]) ? run[i] + 1 : 0;
                if (run[i] == D) begin
                    run[i] = 0;
                    m_st[i] = seen[i];
                    if (seen[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
                end
            end
            full = (bus.data_wr_en == 4'hF) && (bus.data_addr == EVA);
            clr  = full ? bus.data_wr[3:0] : 4'h0;
            clrf = full ? bus.data_wr[19:16] : 4'h0;
            m_ev = (m_ev & ~clr) | rise;
            if (FALL) m_evf = (m_evf & ~clrf) | fall;
        end
    end

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        return (a == BASE) ? {28'h0, m_st} :
               (a == EVA)  ? {12'h0, m_evf, 12'h0, m_ev} : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rd", bus.data_rd, m_rd(bus.data_addr));
        chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.data_addr = a;
        #1;
        chk(name, bus.data_rd, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        bus.data_addr  = a;
        bus.data_wr    = d;
        bus.data_wr_en = en;
        tick();
        bus.data_wr_en = 4'h0;
    endtask

    initial begin
        logic [31:0] addrs [7];
        bus.data_addr = BASE; bus.data_wr = '0; bus.data_wr_en = '0;
        repeat (3) tick();
        rdchk("rst_state", BASE, 32'h0);
        rdchk("rst_event", EVA, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (D + 1) tick();
        rdchk("state_before_latency", BASE, 32'h0);
        tick();
        rdchk("state_at_latency", BASE, 32'hF);
        rdchk("event_with_state", EVA, 32'hF);
        chk("irq_lags_event", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_asserts", {31'h0, irq}, 32'h1);

        wr(EVA, 32'h1, 4'b0011);
        rdchk("partial_write_ignored", EVA, 32'hF);
        wr(EVA, 32'h1, 4'b1111);
        rdchk("w1c_bit0", EVA, 32'hE);
        chk("irq_still_set", {31'h0, irq}, 32'h1);
        wr(EVA, 32'hE, 4'b1111);
        rdchk("w1c_all", EVA, 32'h0);
        chk("irq_holds_one_edge", {31'h0, irq}, 32'h1);
        tick();
        chk("irq_deasserts", {31'h0, irq}, 32'h0);

        btn = 4'b1101;
        repeat (D + 3) tick();
        rdchk("release_state", BASE, 32'hD);
        rdchk("release_no_rise", EVA, FALL ? 32'h0002_0000 : 32'h0);
        wr(EVA, 32'hFFFF_FFFF, 4'hF);
        btn = 4'hF;
        repeat (D + 1) tick();
        rdchk("pre_collision_state", BASE, 32'hD);
        wr(EVA, 32'h2, 4'hF);
        rdchk("collision_set_wins", EVA, 32'h2);
        rdchk("collision_state", BASE, 32'hF);
        wr(EVA, 32'hFFFF_FFFF, 4'hF);

        rdchk("unmapped_base8", BASE + 32'd8, 32'h0);
        rdchk("unmapped_led", 32'h2000_0000, 32'h0);
        rdchk("unmapped_zero", 32'h0, 32'h0);
        wr(BASE, 32'h0, 4'hF);
        rdchk("state_readonly", BASE, 32'hF);

        btn = 4'b1011;
        repeat (D + 3) tick();
        btn = 4'hF;
        repeat (D + 3) tick();
        rdchk("fall_event", EVA, FALL ? 32'h0004_0004 : 32'h0000_0004);
        wr(EVA, 32'h0004_0000, 4'hF);
        rdchk("fall_cleared", EVA, 32'h0000_0004);
        wr(EVA, 32'hFFFF_FFFF, 4'hF);

        addrs = '{BASE, EVA, EVA, BASE + 32'd8, 32'h2000_0000, 32'h0, 32'h0};
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(15) == 0) btn[b] = ~btn[b];
            addrs[6] = $urandom;
            bus.data_addr  = addrs[$urandom_range(6)];
            bus.data_wr    = $urandom;
            bus.data_wr_en = ($urandom_range(5) == 0) ? (($urandom_range(2) == 0) ? 4'($urandom) : 4'hF) : 4'h0;
            if ($urandom_range(999) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        bus.data_wr_en = 4'h0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
